// File: rtl/sprite_motion_ctrl_pkg.sv
// Shared encodings for the sprite motion controller: vertical state, animation frame
// and button bit positions. The colour mux imports the same package.
package sprite_motion_ctrl_pkg;

  typedef enum logic [1:0] {
    VS_GROUND = 2'd0,
    VS_JUMP   = 2'd1,
    VS_FALL   = 2'd2
  } vstate_e;

  typedef enum logic [1:0] {
    FR_STAND = 2'd0,
    FR_WALK1 = 2'd1,
    FR_WALK2 = 2'd2,
    FR_AIR   = 2'd3
  } frame_e;

  localparam int BTN_UP    = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;
  localparam int ROM_AW    = 5;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// Sprite motion bus: per-frame controls and scan coordinate in, position,
// ROM addressing and animation state out.
interface sprite_motion_ctrl_if #(
  parameter int CW = 10
);
  logic          frame_tick;
  logic [2:0]    btn;
  logic          ground;
  logic          ceiling;
  logic [CW-1:0] xg;
  logic [CW-1:0] yg;
  logic [CW-1:0] pos_left;
  logic [CW-1:0] pos_top;
  logic          in_box;
  logic [4:0]    rom_x;
  logic [4:0]    rom_y;
  logic [1:0]    frame_sel;
  logic          facing_r;
  logic [1:0]    vstate;

  modport master (
    output frame_tick, btn, ground, ceiling, xg, yg,
    input  pos_left, pos_top, in_box, rom_x, rom_y, frame_sel, facing_r, vstate
  );

  modport slave (
    input  frame_tick, btn, ground, ceiling, xg, yg,
    output pos_left, pos_top, in_box, rom_x, rom_y, frame_sel, facing_r, vstate
  );
endinterface

// File: rtl/sprite_motion_ctrl_vmotion.sv
// Vertical motion: GROUND/JUMP/FALL state, integer velocity with frame-quantised
// acceleration, and the sprite top edge. Everything advances only on tick.
module sprite_vmotion
  import sprite_motion_ctrl_pkg::*;
#(
  parameter int CW       = 10,
  parameter int SPR_H    = 32,
  parameter int Y_MAX    = 479,
  parameter int START_Y  = 300,
  parameter int V_MAX    = 4,
  parameter int ACCEL_FR = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          up,
  input  logic          ground,
  input  logic          ceiling,
  output logic [CW-1:0] pos_top,
  output vstate_e       vstate
);

  localparam int VW = $clog2(V_MAX + 1);
  localparam int AW = cnt_w(ACCEL_FR);
  localparam logic [CW-1:0] Y_LIM    = CW'(Y_MAX - SPR_H + 1);
  localparam logic [VW-1:0] VY_MAX   = VW'(V_MAX);
  localparam logic [VW-1:0] VY_ONE   = VW'(1);
  localparam logic [AW-1:0] ACC_LAST = AW'(ACCEL_FR - 1);

  logic [VW-1:0] vy;
  logic [AW-1:0] acc;
  logic          up_prev;
  logic          up_edge;
  logic          short_hop;
  logic [VW-1:0] step;

  // Rising past the top edge pins the sprite at row 0.
  function automatic logic rise_clamps(input logic [CW-1:0] top, input logic [VW-1:0] s);
    return CW'(s) > top;
  endfunction

  // Landing on the bottom row counts as reaching the floor, overshoot or not.
  function automatic logic fall_clamps(input logic [CW-1:0] top, input logic [VW-1:0] s);
    return ({1'b0, top} + (CW+1)'(s)) >= {1'b0, Y_LIM};
  endfunction

  always_comb begin
    up_edge   = up & ~up_prev;
    short_hop = ~up && (vy > VY_ONE);
    step      = short_hop ? VY_ONE : vy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_top <= CW'(START_Y);
      vstate  <= VS_GROUND;
      vy      <= '0;
      acc     <= '0;
      up_prev <= 1'b0;
    end else if (tick) begin
      up_prev <= up;
      case (vstate)
        VS_GROUND: begin
          if (!ground) begin
            vstate <= VS_FALL;
            vy     <= VY_ONE;
            acc    <= '0;
          end else if (up_edge) begin
            vstate <= VS_JUMP;
            vy     <= VY_MAX;
            acc    <= '0;
          end
        end
        VS_JUMP: begin
          if (ceiling) begin
            vstate <= VS_FALL;
            vy     <= VY_ONE;
            acc    <= '0;
          end else if (rise_clamps(pos_top, step)) begin
            pos_top <= '0;
            vstate  <= VS_FALL;
            vy      <= VY_ONE;
            acc     <= '0;
          end else begin
            pos_top <= pos_top - CW'(step);
            if (short_hop) begin
              vstate <= VS_FALL;
              vy     <= VY_ONE;
              acc    <= '0;
            end else if (acc == ACC_LAST) begin
              acc <= '0;
              if (vy == VY_ONE) begin
                vstate <= VS_FALL;
                vy     <= VY_ONE;
              end else begin
                vy <= vy - VY_ONE;
              end
            end else begin
              acc <= acc + AW'(1);
            end
          end
        end
        VS_FALL: begin
          if (ground) begin
            vstate <= VS_GROUND;
            vy     <= '0;
            acc    <= '0;
          end else if (fall_clamps(pos_top, vy)) begin
            pos_top <= Y_LIM;
            vstate  <= VS_GROUND;
            vy      <= '0;
            acc     <= '0;
          end else begin
            pos_top <= pos_top + CW'(vy);
            if (acc == ACC_LAST) begin
              acc <= '0;
              if (vy != VY_MAX) vy <= vy + VY_ONE;
            end else begin
              acc <= acc + AW'(1);
            end
          end
        end
        default: begin
          vstate <= VS_GROUND;
          vy     <= '0;
          acc    <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite motion controller: horizontal position and facing, walk-cycle
// animation and scan-to-ROM mapping; vertical motion lives in sprite_vmotion.
module sprite_motion_ctrl
  import sprite_motion_ctrl_pkg::*;
#(
  parameter int CW       = 10,
  parameter int SPR_W    = 28,
  parameter int SPR_H    = 32,
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479,
  parameter int START_X  = 300,
  parameter int START_Y  = 300,
  parameter int X_STEP   = 4,
  parameter int V_MAX    = 4,
  parameter int ACCEL_FR = 8,
  parameter int WALK_FR  = 18
) (
  input  logic             clk,
  input  logic             rst,
  sprite_motion_ctrl_if.slave bus
);

  localparam int WW = cnt_w(WALK_FR);
  localparam logic [CW-1:0] X_LIM     = CW'(X_MAX - SPR_W + 1);
  localparam logic [CW-1:0] X_STEP_C  = CW'(X_STEP);
  localparam logic [WW-1:0] WALK_LAST = WW'(WALK_FR - 1);

  logic [CW-1:0] pos_left;
  logic [CW-1:0] pos_top;
  logic          facing_r;
  vstate_e       vst;
  logic          walking;
  logic          walk_ph;
  logic [WW-1:0] wcnt;
  logic          up, left, right, one_dir;
  frame_e        fsel;
  logic [ROM_AW-1:0] dx, dy;

  function automatic logic [CW-1:0] step_left(input logic [CW-1:0] x);
    return (x < X_STEP_C) ? '0 : x - X_STEP_C;
  endfunction

  function automatic logic [CW-1:0] step_right(input logic [CW-1:0] x);
    return (x >= X_LIM - X_STEP_C) ? X_LIM : x + X_STEP_C;
  endfunction

  assign up      = bus.btn[BTN_UP];
  assign left    = bus.btn[BTN_LEFT];
  assign right   = bus.btn[BTN_RIGHT];
  assign one_dir = left ^ right;

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_left <= CW'(START_X);
      facing_r <= 1'b0;
      walking  <= 1'b0;
      walk_ph  <= 1'b0;
      wcnt     <= '0;
    end else if (bus.frame_tick) begin
      if (left && !right) begin
        pos_left <= step_left(pos_left);
        facing_r <= 1'b0;
      end else if (right && !left) begin
        pos_left <= step_right(pos_left);
        facing_r <= 1'b1;
      end
      // Walk cycle runs only while standing on ground with a single direction held.
      if (one_dir && vst == VS_GROUND) begin
        walking <= 1'b1;
        if (wcnt == WALK_LAST) begin
          wcnt    <= '0;
          walk_ph <= ~walk_ph;
        end else begin
          wcnt <= wcnt + WW'(1);
        end
      end else begin
        walking <= 1'b0;
        walk_ph <= 1'b0;
        wcnt    <= '0;
      end
    end
  end

  sprite_vmotion #(
    .CW       (CW),
    .SPR_H    (SPR_H),
    .Y_MAX    (Y_MAX),
    .START_Y  (START_Y),
    .V_MAX    (V_MAX),
    .ACCEL_FR (ACCEL_FR)
  ) u_vmotion (
    .clk     (clk),
    .rst     (rst),
    .tick    (bus.frame_tick),
    .up      (up),
    .ground  (bus.ground),
    .ceiling (bus.ceiling),
    .pos_top (pos_top),
    .vstate  (vst)
  );

  always_comb begin
    fsel = FR_STAND;
    if (vst != VS_GROUND) fsel = FR_AIR;
    else if (walking)     fsel = walk_ph ? FR_WALK2 : FR_WALK1;
  end

  // Only the low ROM-address bits of the offsets matter, so subtract at that width.
  assign dx = bus.xg[ROM_AW-1:0] - pos_left[ROM_AW-1:0];
  assign dy = bus.yg[ROM_AW-1:0] - pos_top[ROM_AW-1:0];

  assign bus.in_box    = (bus.xg >= pos_left) && (bus.xg <= pos_left + CW'(SPR_W - 1)) &&
                         (bus.yg >= pos_top)  && (bus.yg <= pos_top  + CW'(SPR_H - 1));
  assign bus.rom_x     = facing_r ? dx : ROM_AW'(SPR_W - 1) - dx;
  assign bus.rom_y     = dy;
  assign bus.pos_left  = pos_left;
  assign bus.pos_top   = pos_top;
  assign bus.facing_r  = facing_r;
  assign bus.frame_sel = fsel;
  assign bus.vstate    = vst;

endmodule
